// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP camera-side transmitter.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } dvp_state_e;

    localparam bit BYTE_HI_FIRST = 1'b1;

    // Line period in pclk slots: two bytes per active pixel plus horizontal blank.
    function automatic int line_len(input int h_active, input int h_blank);
        return 2 * h_active + h_blank;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// pclk phase, horizontal/vertical slot counters and the frame FSM.
// Everything advances once per slot, on the clk where the phase bit falls.
module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_pclk,
    output logic o_slot_strobe,
    output logic o_href_window,
    output logic o_vsync_window,
    output logic o_byte_sel,
    output logic o_frame_end
);

    localparam int L     = line_len(H_ACTIVE, H_BLANK);
    localparam int HW    = $clog2(L);
    localparam int V_MAX = max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);
    localparam int VW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(L - 1);
    localparam logic [HW-1:0] H_HREF   = HW'(2 * H_ACTIVE);
    localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LINES - 1);
    localparam logic [VW-1:0] VB_LAST  = VW'(V_BACK - 1);
    localparam logic [VW-1:0] VA_LAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VF_LAST  = VW'(V_FRONT - 1);

    if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_BLANK < 1 ||
        VSYNC_LINES < 1 || V_BACK < 1 || V_FRONT < 1) begin : g_param_chk
        $error("dvp_timing_gen: all timing parameters must be >= 1");
    end

    logic             r_ph;
    dvp_state_e       r_state;
    dvp_state_e       w_next_state;
    logic [HW-1:0]    r_h_cnt;
    logic [HW-1:0]    w_h_next;
    logic [VW-1:0]    r_v_cnt;
    logic [VW-1:0]    w_v_next;
    logic             w_line_end;

    assign w_line_end = (r_h_cnt == H_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph    <= 1'b0;
            r_state <= ST_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_ph    <= ~r_ph;
            r_state <= w_next_state;
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    // r_ph high means this clk is the pclk falling edge: the slot boundary.
    always_comb begin
        w_next_state = r_state;
        w_h_next     = r_h_cnt;
        w_v_next     = r_v_cnt;
        o_frame_end  = 1'b0;
        if (r_ph) begin
            w_h_next = w_line_end ? '0 : r_h_cnt + 1'b1;
            if (w_line_end) w_v_next = r_v_cnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    w_h_next = '0;
                    w_v_next = '0;
                    if (i_en) w_next_state = ST_VSYNC;
                end
                ST_VSYNC: begin
                    if (w_line_end && r_v_cnt == VS_LAST) begin
                        w_next_state = ST_VBACK;
                        w_v_next     = '0;
                    end
                end
                ST_VBACK: begin
                    if (w_line_end && r_v_cnt == VB_LAST) begin
                        w_next_state = ST_ACTIVE;
                        w_v_next     = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_line_end && r_v_cnt == VA_LAST) begin
                        w_next_state = ST_VFRONT;
                        w_v_next     = '0;
                    end
                end
                ST_VFRONT: begin
                    if (w_line_end && r_v_cnt == VF_LAST) begin
                        o_frame_end  = 1'b1;
                        w_v_next     = '0;
                        w_next_state = i_en ? ST_VSYNC : ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    assign o_pclk         = r_ph;
    assign o_slot_strobe  = r_ph;
    assign o_vsync_window = (r_state == ST_VSYNC);
    assign o_href_window  = (r_state == ST_ACTIVE) && (r_h_cnt < H_HREF);
    assign o_byte_sel     = r_h_cnt[0];

endmodule

// File: rtl/dvp_tx.sv
// Camera-side DVP transmitter: RGB565 stream in, pclk/href/vsync/8-bit data out.
// Holds one pixel ahead of the line; an empty buffer at a pixel slot emits zeros.
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] i_pix_data,
    input  logic        i_pix_vld,
    output logic        o_pix_ready,
    output logic        o_pclk,
    output logic [7:0]  o_data,
    output logic        o_href,
    output logic        o_vsync,
    output logic        o_frame_done,
    output logic        o_underrun
);

    logic        w_slot_strobe;
    logic        w_href_window;
    logic        w_vsync_window;
    logic        w_byte_sel;
    logic        w_frame_end;

    logic        r_full;
    logic [15:0] r_hold;
    logic [7:0]  r_lo;
    logic [7:0]  r_data;
    logic        r_href;
    logic        r_vsync;
    logic        r_done;
    logic        r_underrun;

    logic        w_accept;
    logic        w_hi_slot;
    logic        w_consume;
    logic [7:0]  w_first;
    logic [7:0]  w_second;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .clk            (clk),
        .rst            (rst),
        .i_en           (i_en),
        .o_pclk         (o_pclk),
        .o_slot_strobe  (w_slot_strobe),
        .o_href_window  (w_href_window),
        .o_vsync_window (w_vsync_window),
        .o_byte_sel     (w_byte_sel),
        .o_frame_end    (w_frame_end)
    );

    assign o_pix_ready = ~r_full & ~rst;
    assign w_accept    = i_pix_vld & o_pix_ready;
    assign w_hi_slot   = w_slot_strobe & w_href_window & ~w_byte_sel;
    assign w_consume   = w_hi_slot & r_full;
    assign w_first     = BYTE_HI_FIRST ? r_hold[15:8] : r_hold[7:0];
    assign w_second    = BYTE_HI_FIRST ? r_hold[7:0]  : r_hold[15:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= 1'b0;
            r_data     <= '0;
            r_href     <= 1'b0;
            r_vsync    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_full <= (r_full & ~w_consume) | w_accept;
            r_done <= w_frame_end;
            if (w_slot_strobe) begin
                r_href  <= w_href_window;
                r_vsync <= w_vsync_window;
                if (!w_href_window) begin
                    r_data <= '0;
                end else if (w_byte_sel) begin
                    r_data <= r_lo;
                end else if (r_full) begin
                    r_data <= w_first;
                end else begin
                    r_data     <= '0;
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    // Pixel payload needs no reset: r_full alone says whether r_hold is meaningful.
    always_ff @(posedge clk) begin
        if (w_accept) r_hold <= i_pix_data;
        if (w_hi_slot) r_lo <= r_full ? w_second : '0;
    end

    assign o_data       = r_data;
    assign o_href       = r_href;
    assign o_vsync      = r_vsync;
    assign o_frame_done = r_done;
    assign o_underrun   = r_underrun;

endmodule
